// File: rtl/bus_fifo_pkg.sv
// Shared constants and helpers for the per-node bus transmit FIFO.
// Used by bus_node_tx_fifo and its saturating drop counter.
package bus_fifo_pkg;

   localparam int ID_W       = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
   localparam int DROP_CNT_W = 8;
   localparam int MAX_PKT_W  = 64;

   // Destination ID lives in the top ID_W bits of a packet of width pkt_w.
   function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pkt_w);
      return pkt[pkt_w-1 -: ID_W];
   endfunction

endpackage

// File: rtl/bus_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module bus_sat_cnt #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [width-1:0] value
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= '0;
      else if (clear)
         value <= '0;
      else if (inc && (value != {width{1'b1}}))
         value <= value + width'(1);
   end

endmodule

// File: rtl/bus_node_tx_fifo.sv
// Per-node transmit FIFO feeding the bus arbiter, first-word fall-through.
// Optional self-address filtering is enabled by BUS_FIFO_SELF_ADDR_CHECK_EN.
module bus_node_tx_fifo
   import bus_fifo_pkg::*;
#(
   parameter int pckg_sz = 16,
   parameter int depth   = 8,
   parameter int drvr_id = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [pckg_sz-1:0]         D_push,
   input  logic                       pop,
   output logic [pckg_sz-1:0]         D_pop,
   output logic                       pndng,
   output logic                       full,
   output logic [$clog2(depth+1)-1:0] count,
   output logic [DROP_CNT_W-1:0]      drop_cnt,
   output logic                       undfl
`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
   , output logic                     self_err
`endif
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth+1);

   if (depth < 2 || (depth & (depth - 1)) != 0 || drvr_id < 0 || drvr_id > 254 ||
       pckg_sz < ID_W || pckg_sz > MAX_PKT_W) begin : g_bad_param
      $error("bus_node_tx_fifo: illegal parameter combination");
   end

   logic [pckg_sz-1:0] mem [depth];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               pop_ok;
   logic               self_hit;
   logic               push_acc;
   logic               drop_ev;
   logic [CW-1:0]      count_nxt;

   assign pndng = (count != '0);
   assign full  = (count == CW'(depth));
   assign D_pop = pndng ? mem[rd_ptr] : '0;

`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
   logic [ID_W-1:0] dest;
   assign dest     = get_dest(MAX_PKT_W'(D_push), pckg_sz);
   assign self_hit = (dest == ID_W'(drvr_id)) && (dest != BCAST_ID);
`else
   assign self_hit = 1'b0;
`endif

   // A pop on the same edge frees the slot a full FIFO needs for the push.
   always_comb begin
      pop_ok    = pop & pndng;
      push_acc  = push & ~self_hit & (~full | pop_ok);
      drop_ev   = push & (self_hit | (full & ~pop_ok));
      count_nxt = count + CW'(push_acc) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         undfl  <= 1'b0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         if (pop && !pndng)
            undfl <= 1'b1;
      end
   end

   // Storage carries no reset; D_pop masks stale contents whenever empty.
   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr] <= D_push;
   end

`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         self_err <= 1'b0;
      else if (push && self_hit)
         self_err <= 1'b1;
   end
`endif

   bus_sat_cnt #(
      .width(DROP_CNT_W)
   ) u_drop_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(1'b0),
      .inc  (drop_ev),
      .value(drop_cnt)
   );

endmodule

// File: tb/tb_bus_node_tx_fifo.sv
// Directed self-checking bench for bus_node_tx_fifo (default build and,
// when BUS_FIFO_SELF_ADDR_CHECK_EN is defined, the self-address filter).
module tb_bus_node_tx_fifo;

   logic        clk;
   logic        reset;
   logic        push;
   logic [15:0] D_push;
   logic        pop;
   logic [15:0] D_pop;
   logic        pndng;
   logic        full;
   logic [3:0]  count;
   logic [7:0]  drop_cnt;
   logic        undfl;
`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
   logic        self_err;
`endif

   int checks;
   int errors;

   bus_node_tx_fifo #(
      .pckg_sz(16),
      .depth  (8),
      .drvr_id(3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .D_push  (D_push),
      .pop     (pop),
      .D_pop   (D_pop),
      .pndng   (pndng),
      .full    (full),
      .count   (count),
      .drop_cnt(drop_cnt),
      .undfl   (undfl)
`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
      , .self_err(self_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive inputs after the last edge, advance one edge, settle before sampling.
   task automatic applyStimulus(input logic p, input logic [15:0] d, input logic q);
      push   = p;
      D_push = d;
      pop    = q;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      push   = 1'b0;
      pop    = 1'b0;
      D_push = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_pndng", 32'(pndng), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
      checkOutput("rst_undfl", 32'(undfl), 32'd0);
      checkOutput("rst_dpop", 32'(D_pop), 32'd0);
      reset = 1'b0;
      #1;

      // Basic push then drain
      applyStimulus(1'b1, 16'hA001, 1'b0);
      checkOutput("t1_latency", 32'(D_pop), 32'hA001);
      applyStimulus(1'b1, 16'hA002, 1'b0);
      applyStimulus(1'b1, 16'hA003, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("t1_count3", 32'(count), 32'd3);
      checkOutput("t1_pndng", 32'(pndng), 32'd1);
      checkOutput("t1_head", 32'(D_pop), 32'hA001);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t1_pop1", 32'(D_pop), 32'hA002);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t1_pop2", 32'(D_pop), 32'hA003);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t1_empty_pndng", 32'(pndng), 32'd0);
      checkOutput("t1_empty_count", 32'(count), 32'd0);
      checkOutput("t1_empty_dpop", 32'(D_pop), 32'd0);
      checkOutput("t1_no_undfl", 32'(undfl), 32'd0);

      // Fill, overflow and drop counter saturation
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
      checkOutput("t2_full", 32'(full), 32'd1);
      checkOutput("t2_count8", 32'(count), 32'd8);
      applyStimulus(1'b1, 16'hBEEF, 1'b0);
      checkOutput("t2_count_hold", 32'(count), 32'd8);
      checkOutput("t2_drop1", 32'(drop_cnt), 32'd1);
      checkOutput("t2_head", 32'(D_pop), 32'h1000);
      for (int i = 0; i < 300; i++)
         applyStimulus(1'b1, 16'hDEAD, 1'b0);
      checkOutput("t2_drop_sat", 32'(drop_cnt), 32'd255);

      // Push+pop while full: no drop, new word lands at the tail
      applyStimulus(1'b1, 16'h1234, 1'b1);
      checkOutput("t3_count", 32'(count), 32'd8);
      checkOutput("t3_drop", 32'(drop_cnt), 32'd255);
      for (int i = 0; i < 8; i++) begin
         logic [15:0] exp_word;
         exp_word = (i == 7) ? 16'h1234 : 16'h1001 + 16'(i);
         checkOutput($sformatf("t3_order%0d", i), 32'(D_pop), 32'(exp_word));
         applyStimulus(1'b0, 16'h0000, 1'b1);
      end
      checkOutput("t3_drained", 32'(count), 32'd0);

      // Underflow, then simultaneous pop+push on empty
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t4_undfl", 32'(undfl), 32'd1);
      checkOutput("t4_count0", 32'(count), 32'd0);
      applyStimulus(1'b1, 16'h0055, 1'b1);
      checkOutput("t4_count1", 32'(count), 32'd1);
      checkOutput("t4_dpop", 32'(D_pop), 32'h0055);
      checkOutput("t4_undfl_sticky", 32'(undfl), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t4_empty", 32'(count), 32'd0);

      // Interleaved stream across pointer wrap
      for (int k = 0; k < 12; k++) begin
         if (k > 0)
            checkOutput($sformatf("t5_order%0d", k - 1), 32'(D_pop), 32'hC000 + 32'(k - 1));
         applyStimulus(1'b1, 16'hC000 + 16'(k), k > 0);
      end
      checkOutput("t5_order11", 32'(D_pop), 32'hC00B);
      checkOutput("t5_count1", 32'(count), 32'd1);
      applyStimulus(1'b1, 16'hC00C, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("t5_count2", 32'(count), 32'd2);

      // Asynchronous reset mid-stream
      push  = 1'b1;
      pop   = 1'b1;
      reset = 1'b1;
      #1;
      checkOutput("t5_async_pndng", 32'(pndng), 32'd0);
      checkOutput("t5_async_count", 32'(count), 32'd0);
      checkOutput("t5_async_undfl", 32'(undfl), 32'd0);
      checkOutput("t5_async_drop", 32'(drop_cnt), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("t5_rst_ignore", 32'(count), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 16'h0777, 1'b0);
      checkOutput("t5_first_push", 32'(D_pop), 32'h0777);
      checkOutput("t5_first_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("t5_final_empty", 32'(count), 32'd0);

`ifdef BUS_FIFO_SELF_ADDR_CHECK_EN
      // Self-addressed packet is filtered, broadcast passes
      applyStimulus(1'b1, 16'h03AA, 1'b0);
      checkOutput("t6_self_count", 32'(count), 32'd0);
      checkOutput("t6_self_err", 32'(self_err), 32'd1);
      checkOutput("t6_self_drop", 32'(drop_cnt), 32'd1);
      applyStimulus(1'b1, 16'hFFAA, 1'b0);
      checkOutput("t6_bcast_count", 32'(count), 32'd1);
      checkOutput("t6_bcast_dpop", 32'(D_pop), 32'hFFAA);
      applyStimulus(1'b1, 16'h01BB, 1'b0);
      checkOutput("t6_other_count", 32'(count), 32'd2);
      checkOutput("t6_err_sticky", 32'(self_err), 32'd1);
      checkOutput("t6_drop_hold", 32'(drop_cnt), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b0);
`else
      // Without the filter, a packet addressed to this node is stored
      applyStimulus(1'b1, 16'h03AA, 1'b0);
      checkOutput("t6_nofilter_count", 32'(count), 32'd1);
      checkOutput("t6_nofilter_dpop", 32'(D_pop), 32'h03AA);
      checkOutput("t6_nofilter_drop", 32'(drop_cnt), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_node_tx_fifo.md
Name: bus_node_tx_fifo

Overview:
Per-node transmit buffer sitting directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr), one instance per driver slot.
- Host/agent side pushes packets in.
- Bus side presents the head packet on D_pop with pndng and retires it on pop from the arbiter.
- Provides occupancy, overflow-drop counting and an underflow flag for the scoreboard and checker.

Parameters:
pckg_sz, 16, packet width in bits; the destination ID is bits [pckg_sz-1 -: 8].
depth, 8, FIFO entries; must be a power of two and at least 2.
drvr_id, 0, ID of this node (0..254); used by the optional feature.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
push  in  1  host write strobe
D_push  in  pckg_sz  host write data
pop  in  1  bus arbiter retire strobe for the head entry
D_pop  out  pckg_sz  head entry (first-word fall-through)
pndng  out  1  FIFO non-empty
full  out  1  count == depth
count  out  $clog2(depth+1)  current occupancy
drop_cnt  out  8  packets dropped on push-while-full; saturates at 255
undfl  out  1  sticky: pop seen while empty

Behaviour:
- Reset is asynchronous and active-high, named clk/reset as elsewhere in the codebase. While reset=1: pointers=0, count=0, pndng=0, full=0, drop_cnt=0, undfl=0, D_pop=0.
- Storage:
  - depth x pckg_sz register array; write and read pointers of $clog2(depth) bits, wrapping naturally modulo depth.
  - Count register is kept separately.
- Outputs:
  - D_pop = mem[rd_ptr] when pndng=1, else 0.
  - pndng = (count != 0); full = (count == depth). Both are registered-state derived with no combinational path from push or pop.
- Push latency: a packet accepted at edge N appears on D_pop/pndng after edge N if the FIFO was empty (1-cycle write-to-visible latency).
- Pop: with pop=1 and pndng=1 at an edge, rd_ptr++ and count--. The next entry, or pndng=0, is visible after that edge.
- Push accepted iff push=1 and (not full, or pop=1 with pndng=1 in the same cycle).
- Push while full without pop: data discarded, count unchanged, drop_cnt += 1 (holds at 255).
- Pop while empty: no pointer or count change; undfl sets and stays set until reset.
- Simultaneous push and pop:
  - non-empty, not full: both performed, count unchanged.
  - full: both performed, no drop.
  - empty: pop is an underflow (undfl sets), push is accepted, count becomes 1.
- Reset mid-operation: all contents are lost immediately (asynchronous). push/pop during reset are ignored. First accepted push is on the first edge after reset deasserts.
- No packet reordering; strict FIFO order is preserved across pointer wrap.

Optional Feature:
Macro: BUS_FIFO_SELF_ADDR_CHECK_EN
- Defined:
  - A push whose destination field equals drvr_id is dropped and not stored, because the bus cannot deliver to its own source.
  - Such a drop increments drop_cnt (shares saturation).
  - Extra output self_err (1 bit) is sticky, cleared only by reset.
  - Broadcast ID 8'hFF is always accepted.
- Not defined: destination is not inspected, self_err does not exist, and every non-full push is stored.

Decomposition:
- Package bus_fifo_pkg:
  - ID_W = 8
  - BCAST_ID = 8'hFF
  - DROP_CNT_W = 8
  - function get_dest(pkt) returning the top ID_W bits
- One sub-module: bus_sat_cnt (parameterised width, inc/clear, saturating at all-ones), instantiated for drop_cnt.

Test Plan:
1. Reset, then push 16'hA001..16'hA003 on 3 consecutive cycles, no pop -> count=3, pndng=1, D_pop=16'hA001; pop 3 times -> D_pop 16'hA002, 16'hA003, then pndng=0, count=0.
2. Fill 8 entries, push 16'hBEEF with pop=0 -> count stays 8, full=1, drop_cnt=1; 300 further full pushes -> drop_cnt=255.
3. FIFO full, push 16'h1234 and pop in the same cycle -> count=8, drop_cnt unchanged, 16'h1234 emerges as the 8th pop.
4. Empty FIFO, pop=1 -> undfl=1, count=0; same cycle push 16'h0055 -> count=1, D_pop=16'h0055; undfl remains 1.
5. Push 12 packets interleaved with 12 pops over a wrap boundary -> output order is identical to input order; assert reset mid-stream -> pndng=0 and count=0 immediately, before the next clock edge.
6. With BUS_FIFO_SELF_ADDR_CHECK_EN and drvr_id=3: push 16'h03AA -> dropped, self_err=1, drop_cnt=1; push 16'hFFAA -> stored.
